// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the load/store controller: access sizes, FSM states and
// the legality check used on request acceptance.
package lib_cpu;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RESP
   } mem_acc_state_t;

   // Size code 3 is folded in here so one call answers "will this request fault".
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SIZE_B:  return 1'b0;
         SIZE_H:  return addr_lo[0];
         SIZE_W:  return (addr_lo != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus word-memory port of the load/store controller.
// master = CPU datapath and memory side, slave = controller.
interface mem_access_ctrl_if #(parameter int ADDR_W = 8);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_w_en;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_w_data;
   logic [31:0]       mem_r_data;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output resp_ready, mem_r_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_w_en, mem_addr, mem_w_data
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  resp_ready, mem_r_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_w_en, mem_addr, mem_w_data
   );
endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// Combinational byte/halfword lane logic: extracts and extends a load value
// and merges sub-word store data into a word; word accesses pass straight through.
module mem_lane_align
   import lib_cpu::*;
(
   input  logic [31:0] word_i,
   input  logic [15:0] wdata_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        signed_i,
   output logic [31:0] load_o,
   output logic [31:0] merged_o
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v   = word_i[{addr_lo_i, 3'b000} +: 8];
      half_v   = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
      load_o   = word_i;
      merged_o = word_i;
      case (size_i)
         SIZE_B: begin
            load_o = {{24{signed_i & byte_v[7]}}, byte_v};
            merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SIZE_H: begin
            load_o = {{16{signed_i & half_v[15]}}, half_v};
            merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller: error->resp T+1, load/word store T+2, sub-word store T+3
// (RMW); one request in flight, response held until resp_ready. Option: MEM_ACCESS_ERR_COUNT_EN.
module mem_access_ctrl
   import lib_cpu::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic clk,
   input  logic reset_n,
   mem_access_ctrl_if.slave bus
`ifdef MEM_ACCESS_ERR_COUNT_EN
   ,
   output logic [15:0] err_count
`endif
);
   mem_acc_state_t    state_q, state_d;
   logic              we_q, signed_q, err_q;
   logic [1:0]        size_q, addr_lo_q;
   logic [15:0]       wdata_lo_q;
   logic [DATA_W-1:0] wr_word_q, rdata_q;
   logic [ADDR_W-3:0] mem_addr_q;
   logic [31:0]       load_val, merged_word;
   logic              accept, req_err;

   assign accept  = (state_q == IDLE) && bus.req_valid;
   assign req_err = is_misaligned(bus.req_size, bus.req_addr[1:0]);

   mem_lane_align u_align (
      .word_i    (bus.mem_r_data),
      .wdata_i   (wdata_lo_q),
      .size_i    (size_q),
      .addr_lo_i (addr_lo_q),
      .signed_i  (signed_q),
      .load_o    (load_val),
      .merged_o  (merged_word)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (req_err)                        state_d = RESP;
               else if (!bus.req_we)               state_d = READ;
               else if (bus.req_size == SIZE_W)    state_d = WRITE;
               else                                state_d = READ;
            end
         end
         READ:    state_d = we_q ? WRITE : RESP;
         WRITE:   state_d = RESP;
         RESP:    if (bus.resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = (state_q == IDLE);
      bus.resp_valid = (state_q == RESP);
      bus.resp_rdata = rdata_q;
      bus.resp_err   = err_q;
      bus.mem_w_en   = (state_q == WRITE);
      bus.mem_addr   = mem_addr_q;
      bus.mem_w_data = (state_q == WRITE) ? wr_word_q : '0;
   end

   // mem_addr_q is only reloaded by a legal request, so errors leave the bus untouched.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         we_q       <= 1'b0;
         signed_q   <= 1'b0;
         err_q      <= 1'b0;
         size_q     <= 2'b00;
         addr_lo_q  <= 2'b00;
         wdata_lo_q <= '0;
         wr_word_q  <= '0;
         rdata_q    <= '0;
         mem_addr_q <= '0;
      end else begin
         if (accept) begin
            we_q       <= bus.req_we;
            signed_q   <= bus.req_signed;
            err_q      <= req_err;
            size_q     <= bus.req_size;
            addr_lo_q  <= bus.req_addr[1:0];
            wdata_lo_q <= bus.req_wdata[15:0];
            wr_word_q  <= bus.req_wdata;
            rdata_q    <= '0;
            if (!req_err) mem_addr_q <= bus.req_addr[ADDR_W-1:2];
         end else if (state_q == READ) begin
            if (we_q) wr_word_q <= merged_word;
            else      rdata_q   <= load_val;
         end
      end
   end

`ifdef MEM_ACCESS_ERR_COUNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_cnt_q <= '0;
      else if (accept && req_err && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
   end

   assign err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// requests scored against an arithmetic reference model of memory and responses.
module tb_mem_access_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mem_access_ctrl_if #(.ADDR_W(8)) ifc();
`ifdef MEM_ACCESS_ERR_COUNT_EN
   logic [15:0] err_count;
`endif

   mem_access_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc)
`ifdef MEM_ACCESS_ERR_COUNT_EN
      ,
      .err_count (err_count)
`endif
   );

   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   logic        pre_we = 1'b0;
   logic [5:0]  pre_addr = '0;
   logic [31:0] pre_dat = '0;

   assign ifc.mem_r_data = mem[ifc.mem_addr];

   always @(posedge clk) begin
      if (ifc.mem_w_en === 1'b1) mem[ifc.mem_addr] <= ifc.mem_w_data;
      else if (pre_we)           mem[pre_addr]     <= pre_dat;
   end

   int          wr_total = 0;
   int          wr_cyc = 0;
   logic [5:0]  wr_addr = '0;
   logic [31:0] wr_dat = '0;
   always @(negedge clk) begin
      if (ifc.mem_w_en === 1'b1) begin
         wr_total <= wr_total + 1;
         wr_cyc   <= cyc;
         wr_addr  <= ifc.mem_addr;
         wr_dat   <= ifc.mem_w_data;
      end
   end

   int errors = 0;
   int checks = 0;
   int acc = 0;
   int wr_base = 0;

   // Reference model: expected response, latency and memory effect of one request.
   task automatic model_req(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [7:0] ad, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er, output int lat,
                            output int wlat, output logic [31:0] wword);
      logic [5:0]  idx;
      logic [1:0]  off;
      logic [31:0] word, v, mask;
      idx = ad[7:2];
      off = ad[1:0];
      word = ref_mem[idx];
      er = (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
      rd = '0; wlat = 0; wword = '0; lat = 1;
      if (er) begin
         lat = 1;
      end else if (!we) begin
         lat = 2;
         if (sz == 2'd2) rd = word;
         else begin
            v = (sz == 2'd0) ? ((word >> {off, 3'b000}) & 32'hFF) : ((word >> {off, 3'b000}) & 32'hFFFF);
            if (sg && sz == 2'd0 && v >= 32'd128)   v = v + 32'hFFFFFF00;
            if (sg && sz == 2'd1 && v >= 32'd32768) v = v + 32'hFFFF0000;
            rd = v;
         end
      end else if (sz == 2'd2) begin
         lat = 2; wlat = 1; wword = wd;
      end else begin
         lat = 3; wlat = 2;
         mask  = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << {off, 3'b000};
         wword = (word & ~mask) | ((wd << {off, 3'b000}) & mask);
      end
      if (wlat != 0) ref_mem[idx] = wword;
   endtask

   // Drives one request, observes the response; resp_ready is expected high.
   task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [7:0] ad, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat, output int wcnt);
      @(negedge clk);
      ifc.req_valid = 1'b1; ifc.req_we = we; ifc.req_size = sz;
      ifc.req_signed = sg; ifc.req_addr = ad; ifc.req_wdata = wd;
      wr_base = wr_total;
      @(posedge clk); #1;
      acc = cyc;
      ifc.req_valid = 1'b0;
      lat = 0; rd = '0; er = 1'b0;
      for (int i = 0; i < 8 && lat == 0; i++) begin
         @(negedge clk);
         if (ifc.resp_valid === 1'b1) begin
            lat = cyc - acc + 1; rd = ifc.resp_rdata; er = ifc.resp_err;
         end
      end
      @(posedge clk); #1;
      wcnt = wr_total - wr_base;
   endtask

   task automatic test_reset();
      ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_size = 2'd0; ifc.req_signed = 1'b0;
      ifc.req_addr = '0; ifc.req_wdata = '0; ifc.resp_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         pre_we = 1'b1; pre_addr = 6'(i); pre_dat = $urandom; ref_mem[i] = pre_dat;
      end
      @(negedge clk); pre_we = 1'b0;
      checks++; if (ifc.req_ready !== 1'b1 || ifc.resp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_hs: req_ready=%b resp_valid=%b want 1/0", ifc.req_ready, ifc.resp_valid); end
      checks++; if (ifc.resp_rdata !== 32'h0 || ifc.resp_err !== 1'b0) begin
         errors++; $display("FAIL reset_resp: rdata=%h err=%b want 0/0", ifc.resp_rdata, ifc.resp_err); end
      checks++; if (ifc.mem_w_en !== 1'b0 || ifc.mem_addr !== 6'd0 || ifc.mem_w_data !== 32'h0) begin
         errors++; $display("FAIL reset_mem: w_en=%b addr=%h wdata=%h want 0/0/0", ifc.mem_w_en, ifc.mem_addr, ifc.mem_w_data); end
      reset_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (ifc.req_ready !== 1'b1 || ifc.resp_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset: req_ready=%b resp_valid=%b want 1/0", ifc.req_ready, ifc.resp_valid); end
   endtask

   task automatic test_word_store_load();
      logic [31:0] rd, er_w, mr; logic er, me; int lat, wc, ml, mw;
      model_req(1'b1, 2'd2, 1'b0, 8'h08, 32'hDEADBEEF, mr, me, ml, mw, er_w);
      run_req(1'b1, 2'd2, 1'b0, 8'h08, 32'hDEADBEEF, rd, er, lat, wc);
      checks++; if (lat != 2 || er !== 1'b0) begin
         errors++; $display("FAIL wstore_resp: lat=%0d err=%b want 2/0", lat, er); end
      checks++; if (wc != 1 || wr_cyc - acc + 1 != 1) begin
         errors++; $display("FAIL wstore_wen: writes=%0d at T+%0d want 1 at T+1", wc, wr_cyc - acc + 1); end
      checks++; if (wr_addr !== 6'd2 || wr_dat !== 32'hDEADBEEF) begin
         errors++; $display("FAIL wstore_bus: addr=%0d data=%h want 2/deadbeef", wr_addr, wr_dat); end
      model_req(1'b0, 2'd2, 1'b0, 8'h08, 32'h0, mr, me, ml, mw, er_w);
      run_req(1'b0, 2'd2, 1'b0, 8'h08, 32'h0, rd, er, lat, wc);
      checks++; if (rd !== 32'hDEADBEEF || lat != 2 || wc != 0) begin
         errors++; $display("FAIL wload: rdata=%h lat=%0d writes=%0d want deadbeef/2/0", rd, lat, wc); end
   endtask

   task automatic test_byte_store();
      logic [31:0] rd, ew, mr; logic er, me; int lat, wc, ml, mw;
      model_req(1'b1, 2'd0, 1'b0, 8'h09, 32'h000000AA, mr, me, ml, mw, ew);
      run_req(1'b1, 2'd0, 1'b0, 8'h09, 32'h000000AA, rd, er, lat, wc);
      checks++; if (lat != 3 || er !== 1'b0 || rd !== 32'h0) begin
         errors++; $display("FAIL bstore_resp: lat=%0d err=%b rdata=%h want 3/0/0", lat, er, rd); end
      checks++; if (wc != 1 || wr_cyc - acc + 1 != 2 || wr_dat !== 32'hDEADAAEF || wr_addr !== 6'd2) begin
         errors++; $display("FAIL bstore_write: n=%0d T+%0d data=%h addr=%0d want 1/T+2/deadaaef/2",
                            wc, wr_cyc - acc + 1, wr_dat, wr_addr); end
      checks++; if (mem[2] !== 32'hDEADAAEF) begin
         errors++; $display("FAIL bstore_mem: word=%h want deadaaef", mem[2]); end
   endtask

   task automatic test_load_ext();
      logic [7:0]  ta[4] = '{8'h10, 8'h11, 8'h12, 8'h12};
      logic [1:0]  ts[4] = '{2'd0, 2'd0, 2'd1, 2'd1};
      logic        tg[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] te[4] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00008000, 32'hFFFF8000};
      logic [31:0] rd, ew, mr; logic er, me; int lat, wc, ml, mw;
      model_req(1'b1, 2'd2, 1'b0, 8'h10, 32'h8000FF7F, mr, me, ml, mw, ew);
      run_req(1'b1, 2'd2, 1'b0, 8'h10, 32'h8000FF7F, rd, er, lat, wc);
      for (int i = 0; i < 4; i++) begin
         run_req(1'b0, ts[i], tg[i], ta[i], $urandom, rd, er, lat, wc);
         checks++; if (rd !== te[i] || er !== 1'b0 || lat != 2) begin
            errors++; $display("FAIL ext_load%0d: rdata=%h err=%b lat=%0d want %h/0/2", i, rd, er, lat, te[i]); end
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat, wc;
      run_req(1'b0, 2'd2, 1'b0, 8'h06, 32'h0, rd, er, lat, wc);
      checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || wc != 0) begin
         errors++; $display("FAIL err_misalign: err=%b rdata=%h lat=%0d writes=%0d want 1/0/1/0", er, rd, lat, wc); end
      run_req(1'b1, 2'd3, 1'b0, 8'h04, 32'h12345678, rd, er, lat, wc);
      checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || wc != 0) begin
         errors++; $display("FAIL err_size3: err=%b rdata=%h lat=%0d writes=%0d want 1/0/1/0", er, rd, lat, wc); end
`ifdef MEM_ACCESS_ERR_COUNT_EN
      checks++; if (err_count !== 16'd2) begin
         errors++; $display("FAIL err_count: got %0d want 2", err_count); end
`endif
   endtask

   task automatic test_backpressure();
      logic [31:0] e1, e2, ew; logic me; int ml, mw, lat;
      model_req(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, e1, me, ml, mw, ew);
      model_req(1'b0, 2'd2, 1'b0, 8'h08, 32'h0, e2, me, ml, mw, ew);
      @(negedge clk);
      ifc.resp_ready = 1'b0;
      ifc.req_valid = 1'b1; ifc.req_we = 1'b0; ifc.req_size = 2'd2; ifc.req_addr = 8'h10;
      @(posedge clk); #1; acc = cyc; ifc.req_valid = 1'b0;
      lat = 0;
      for (int i = 0; i < 8 && lat == 0; i++) begin
         @(negedge clk); if (ifc.resp_valid === 1'b1) lat = cyc - acc + 1;
      end
      checks++; if (lat != 2) begin errors++; $display("FAIL bp_lat: got %0d want 2", lat); end
      ifc.req_valid = 1'b1; ifc.req_addr = 8'h08;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         checks++; if (ifc.resp_valid !== 1'b1 || ifc.resp_rdata !== e1 || ifc.req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold%0d: valid=%b rdata=%h req_ready=%b want 1/%h/0",
                               i, ifc.resp_valid, ifc.resp_rdata, ifc.req_ready, e1); end
      end
      ifc.resp_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (ifc.resp_valid !== 1'b0 || ifc.req_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: valid=%b req_ready=%b want 0/1", ifc.resp_valid, ifc.req_ready); end
      @(posedge clk); #1; acc = cyc; ifc.req_valid = 1'b0;
      lat = 0;
      for (int i = 0; i < 8 && lat == 0; i++) begin
         @(negedge clk); if (ifc.resp_valid === 1'b1) lat = cyc - acc + 1;
      end
      checks++; if (lat != 2 || ifc.resp_rdata !== e2) begin
         errors++; $display("FAIL bp_second: lat=%0d rdata=%h want 2/%h", lat, ifc.resp_rdata, e2); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      ifc.req_valid = 1'b1; ifc.req_we = 1'b1; ifc.req_size = 2'd0; ifc.req_signed = 1'b0;
      ifc.req_addr = 8'h21; ifc.req_wdata = 32'h00000055;
      wr_base = wr_total;
      @(posedge clk); #1; ifc.req_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      checks++; if (ifc.req_ready !== 1'b1 || ifc.resp_valid !== 1'b0 || ifc.resp_rdata !== 32'h0 || ifc.resp_err !== 1'b0) begin
         errors++; $display("FAIL rstmid_resp: req_ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                            ifc.req_ready, ifc.resp_valid, ifc.resp_rdata, ifc.resp_err); end
      checks++; if (ifc.mem_w_en !== 1'b0 || ifc.mem_addr !== 6'd0 || ifc.mem_w_data !== 32'h0) begin
         errors++; $display("FAIL rstmid_mem: w_en=%b addr=%h wdata=%h want 0/0/0", ifc.mem_w_en, ifc.mem_addr, ifc.mem_w_data); end
      @(posedge clk); @(posedge clk); @(negedge clk);
      reset_n = 1'b1;
      checks++; if (wr_total - wr_base != 0 || mem[8] !== ref_mem[8]) begin
         errors++; $display("FAIL rstmid_nowrite: writes=%0d word=%h want 0/%h", wr_total - wr_base, mem[8], ref_mem[8]); end
`ifdef MEM_ACCESS_ERR_COUNT_EN
      checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rstmid_errcnt: got %0d want 0", err_count); end
`endif
   endtask

   task automatic test_random();
      logic we, sg, er, me; logic [1:0] sz; logic [7:0] ad; logic [31:0] wd, rd, mr, ew;
      int lat, wc, ml, mw;
      for (int n = 0; n < 60; n++) begin
         we = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3)); ad = 8'($urandom_range(0, 255)); wd = $urandom;
         model_req(we, sz, sg, ad, wd, mr, me, ml, mw, ew);
         run_req(we, sz, sg, ad, wd, rd, er, lat, wc);
         checks++; if (rd !== mr || er !== me || lat != ml) begin
            errors++; $display("FAIL rand%0d_resp: we=%b sz=%0d a=%h rdata=%h err=%b lat=%0d want %h/%b/%0d",
                               n, we, sz, ad, rd, er, lat, mr, me, ml); end
         checks++; if (wc != ((mw != 0) ? 1 : 0)) begin
            errors++; $display("FAIL rand%0d_wcnt: writes=%0d want %0d", n, wc, (mw != 0) ? 1 : 0); end
         if (mw != 0 && wc == 1) begin
            checks++; if (wr_dat !== ew || wr_addr !== ad[7:2] || wr_cyc - acc + 1 != mw) begin
               errors++; $display("FAIL rand%0d_write: data=%h addr=%0d T+%0d want %h/%0d/T+%0d",
                                  n, wr_dat, wr_addr, wr_cyc - acc + 1, ew, ad[7:2], mw); end
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_word_store_load();
      test_byte_store();
      test_load_ext();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
